// File: rtl/onehot_hold_decoder_pkg.sv
// Shared types and constants for the one-hot hold decoder.
// Line count and index width match the 4:2 priority encoder.
package onehot_hold_decoder_pkg;

    localparam int IDX_W   = 2;
    localparam int N_LINES = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [N_LINES-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N_LINES'(1) << idx;
    endfunction

endpackage

// File: rtl/onehot_hold_decoder_if.sv
// Encoder-link interface: encoded word in, held one-hot lines out.
// Overrun flag and its clear exist only with DECODER_OVR_EN.
interface onehot_hold_decoder_if;
    import onehot_hold_decoder_pkg::*;

    logic               in_valid;
    logic [IDX_W-1:0]   in_idx;
    logic [N_LINES-1:0] out_w;
    logic               busy;

`ifdef DECODER_OVR_EN
    logic ovr;
    logic ovr_clr;

    modport master (
        output in_valid, in_idx, ovr_clr,
        input  out_w, busy, ovr
    );

    modport slave (
        input  in_valid, in_idx, ovr_clr,
        output out_w, busy, ovr
    );
`else
    modport master (
        output in_valid, in_idx,
        input  out_w, busy
    );

    modport slave (
        input  in_valid, in_idx,
        output out_w, busy
    );
`endif

endinterface

// File: rtl/onehot_hold_decoder_hold_counter.sv
// Loadable down-counter with zero flag; load has priority over decrement.
module hold_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/onehot_hold_decoder.sv
// Registered 2:4 decoder with programmable pulse stretch.
// Optional sticky retrigger flag enabled by DECODER_OVR_EN.
module onehot_hold_decoder
    import onehot_hold_decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    onehot_hold_decoder_if.slave bus
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t             state;
    logic [N_LINES-1:0] out_w;
    logic               cnt_zero;
    logic               cnt_dec;

    // Any accepted word reloads, so a final-cycle retrigger leaves no gap.
    assign cnt_dec = (state == HOLD) && !bus.in_valid && !cnt_zero;

    hold_counter #(
        .CNT_W(CNT_W)
    ) u_hold_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (bus.in_valid),
        .load_val (RELOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            out_w <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        out_w <= onehot(bus.in_idx);
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.in_valid) begin
                        out_w <= onehot(bus.in_idx);
                    end else if (cnt_zero) begin
                        out_w <= '0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.out_w = out_w;
    assign bus.busy  = (state == HOLD);

`ifdef DECODER_OVR_EN
    logic ovr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr <= 1'b0;
        end else if (bus.in_valid && (state == HOLD)) begin
            ovr <= 1'b1;
        end else if (bus.ovr_clr) begin
            ovr <= 1'b0;
        end
    end

    assign bus.ovr = ovr;
`endif

endmodule

// File: doc/onehot_hold_decoder.md
# onehot_hold_decoder

Registered 2:4 decoder that receives the encoded output of the 4:2 priority encoder (index plus valid) and regenerates the corresponding one-hot line. Each decoded line is held for a programmable number of cycles (pulse stretch) so that one-cycle encoder events drive downstream indicators and enables. The block sits on the receiving side of the encoder link and performs the inverse mapping, with timing added.

## Interface
- HOLD_CYCLES, 4: number of cycles a decoded line stays asserted; legal range 1..255.
- CNT_W, $clog2(HOLD_CYCLES+1): hold counter width; derived, not overridden.

- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  encoded word present; driven as the inverse of the encoder's zero flag
- in_idx  input  2  encoded index; 0 = line 0 … 3 = line 3
- out_w  output  4  registered one-hot decoded lines; all zero when idle
- busy  output  1  high while any out_w line is held
- ovr  output  1  sticky retrigger flag; present only with DECODER_OVR_EN
- ovr_clr  input  1  clears ovr; present only with DECODER_OVR_EN

## Operation
- States: IDLE and HOLD.
- In IDLE, in_valid=1 sampled at an edge:
  - Loads out_w = 1 << in_idx.
  - Loads the counter with HOLD_CYCLES-1.
  - Moves to HOLD.
- In HOLD with in_valid=0:
  - Counter decrements each cycle.
  - When the counter is 0, the next edge clears out_w and returns to IDLE.
- In HOLD with in_valid=1 (retrigger):
  - out_w reloads to 1 << in_idx, which may be a different or the same line.
  - Counter reloads to HOLD_CYCLES-1.
  - State stays HOLD.
  - A retrigger on the final hold cycle also reloads, so there is no gap cycle.
- out_w is always one-hot or zero. Two bits are never high at once.
- busy = (state == HOLD). busy and |out_w are identical.
- in_idx is ignored whenever in_valid=0.
- HOLD_CYCLES=1: counter is loaded with 0, so a line is high for exactly one cycle per accepted input.

## Timing
- Reset values: out_w=4'b0000, busy=0, ovr=0, counter=0, state=IDLE.
- Reset is asynchronous. Asserting rst mid-hold clears every output immediately, without waiting for a clock edge.
- After rst deasserts, the first in_valid is accepted on the next rising edge.
- Latency: in_valid sampled at edge N gives out_w valid after edge N.
  - Without a retrigger, out_w stays high for exactly HOLD_CYCLES cycles.
  - It drops after edge N+HOLD_CYCLES.
- Continuous in_valid keeps the output held indefinitely. out_w follows in_idx with 1-cycle latency.
- No combinational path from inputs to outputs.

## Configuration
- DECODER_OVR_EN defined:
  - ovr sets on any edge where in_valid=1 while busy=1, i.e. a retrigger that truncated or extended a hold.
  - ovr stays set until ovr_clr=1 at an edge or rst.
  - When set and clear occur on the same edge, set wins.
- DECODER_OVR_EN undefined:
  - ovr and ovr_clr ports are absent.
  - No overrun logic is generated.
  - All other behaviour is identical.

## Structure
- Shared package holds:
  - the state typedef (IDLE, HOLD);
  - the index width constant (2);
  - the line-count constant (4), shared with the priority encoder.
- One sub-module, hold_counter: loadable down-counter with a zero flag, parameterised by CNT_W.
  - The decoder FSM and the one-hot register stay in the top module.

## Test plan
- Reset behaviour: rst pulsed mid-hold, with no clock edge → out_w=0000, busy=0, ovr=0 immediately.
- Basic decode, HOLD_CYCLES=4: in_valid=1 for 1 cycle with in_idx=2 → out_w=0100 for exactly 4 cycles, then 0000; busy tracks out_w.
- All indices: idx 0..3 each sent singly with idle gaps → out_w = 0001, 0010, 0100, 1000; never two bits set.
- Retrigger: idx=1 at edge 0, idx=3 at edge 2 → out_w=0010 for 2 cycles, then 1000 for 4 cycles; ovr=1 when DECODER_OVR_EN is defined.
- Boundary cases:
  - HOLD_CYCLES=1 with back-to-back in_valid on idx 0,0,3 → out_w = 0001, 0001, 1000, then 0000.
  - Retrigger on the final hold cycle → no zero cycle between the two holds.
- Overrun clear: ovr=1, then ovr_clr=1 alone → ovr=0; ovr_clr=1 together with a retrigger → ovr stays 1.
